// File: rtl/hc595_pkg.sv
// Shared framing definitions for the 74HC595 tube link: widths, receiver FSM states and
// the serial bit-order mapping used by both the serializer and the receiver.
package hc595_pkg;

  localparam int SEL_W      = 6;
  localparam int SEG_W      = 8;
  localparam int FRAME_BITS = SEL_W + SEG_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    OVER
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SEG_W-1:0] seg;
  } frame_t;

  // sel[0] is shifted first so it ends up in the MSB; seg[7] follows sel[5].
  function automatic frame_t unpack_frame(input logic [FRAME_BITS-1:0] sr);
    frame_t f;
    for (int i = 0; i < SEL_W; i++) begin
      f.sel[i] = sr[FRAME_BITS-1-i];
    end
    f.seg = sr[SEG_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/hc595_edge_det.sv
// Single-register rise detector; the rise flag is valid in the same cycle the input first
// reads high, so the consumer acts on the very clock edge that samples it.
module hc595_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/hc595_frame_rx.sv
// Receive-side model of the 74HC595 chain: rebuilds sel/seg from shcp/stcp/ds/oe and adds
// bit-count and stall checks that the real shift register cannot report.
module hc595_frame_rx
  import hc595_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shcp,
  input  logic             stcp,
  input  logic             ds,
  input  logic             oe,
  output logic [SEL_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic             blank,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic shcp_rise;
  logic stcp_rise;

  hc595_edge_det u_shcp_det (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (shcp),
    .rise (shcp_rise)
  );

  hc595_edge_det u_stcp_det (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (stcp),
    .rise (stcp_rise)
  );

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  blank_q, blank_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  state_e                st_shift;
  logic [CW-1:0]         cnt_shift;
  frame_t                frame;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = idle_q;
    sel_d       = sel_q;
    seg_d       = seg_q;
    blank_d     = oe;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    st_shift    = state_q;
    cnt_shift   = bit_cnt_q;
    frame       = unpack_frame(sr_q);

    // The shift is resolved first so a latch in the same cycle sees the new bit.
    if (shcp_rise) begin
      sr_d = {sr_q[FRAME_BITS-2:0], ds};
      if (bit_cnt_q != CW'(FRAME_BITS + 1)) begin
        cnt_shift = bit_cnt_q + CW'(1);
      end
      case (state_q)
        IDLE:    st_shift = SHIFT;
        SHIFT:   st_shift = (cnt_shift == CW'(FRAME_BITS)) ? FULL : SHIFT;
        FULL:    st_shift = OVER;
        default: st_shift = OVER;
      endcase
      state_d   = st_shift;
      bit_cnt_d = cnt_shift;
      idle_d    = '0;
    end else if (state_q != IDLE) begin
      if (idle_q == IW'(TIMEOUT - 1)) begin
        err_d     = 1'b1;
        state_d   = IDLE;
        bit_cnt_d = '0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end

    if (stcp_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      idle_d    = '0;
      if (st_shift == FULL) begin
        frame       = unpack_frame(sr_d);
        sel_d       = frame.sel;
        seg_d       = frame.seg;
        valid_d     = 1'b1;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      sel_q       <= '0;
      seg_q       <= '0;
      blank_q     <= 1'b1;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_q      <= idle_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      blank_q     <= blank_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sel         = sel_q;
  assign seg         = seg_q;
  assign blank       = blank_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hc595_frame_rx.sv
// Directed bench for hc595_frame_rx: drives shcp/stcp/ds/oe on the falling clock edge and
// checks outputs against hand-computed values with immediate assertions.
module tb_hc595_frame_rx;

  logic        clk;
  logic        rst_n;
  logic        shcp;
  logic        stcp;
  logic        ds;
  logic        oe;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        blank;
  logic        frame_valid;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int n_vec;
  int n_mis;
  int vpulses;
  int epulses;

  hc595_frame_rx #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .shcp       (shcp),
    .stcp       (stcp),
    .ds         (ds),
    .oe         (oe),
    .sel        (sel),
    .seg        (seg),
    .blank      (blank),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse monitor: each output pulse is high for exactly one falling edge.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) vpulses = vpulses + 1;
    if (frame_err === 1'b1) epulses = epulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp)
    else begin
      n_mis = n_mis + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int half);
    @(negedge clk);
    ds   = b;
    shcp = 1'b1;
    repeat (half) @(negedge clk);
    shcp = 1'b0;
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic send_bits(input int n, input int half);
    for (int i = 0; i < n; i++) send_bit(i[0], half);
  endtask

  task automatic send_frame(input logic [5:0] s, input logic [7:0] g, input int half);
    for (int i = 0; i < 6; i++) send_bit(s[i], half);
    for (int i = 7; i >= 0; i--) send_bit(g[i], half);
  endtask

  task automatic latch();
    @(negedge clk);
    stcp = 1'b1;
    @(negedge clk);
    stcp = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [13:0] bits;
    n_vec   = 0;
    n_mis   = 0;
    vpulses = 0;
    epulses = 0;
    rst_n   = 1'b0;
    shcp    = 1'b0;
    stcp    = 1'b0;
    ds      = 1'b0;
    oe      = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_blank", 32'(blank), 32'h1);
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);
    rst_n = 1'b1;

    // Loopback-style frame at the serializer's 4-clk bit period
    send_frame(6'b111110, 8'hC0, 2);
    latch();
    chk("lb_sel", 32'(sel), 32'h3E);
    chk("lb_seg", 32'(seg), 32'hC0);
    chk("lb_vpulses", 32'(vpulses), 32'h1);
    chk("lb_epulses", 32'(epulses), 32'h0);
    chk("lb_cnt", 32'(frame_cnt), 32'h1);

    // Raw bit order: 1,0,0,0,0,0 then 1,0,1,0,0,1,0,1
    bits = 14'b10000010100101;
    for (int i = 13; i >= 0; i--) send_bit(bits[i], 1);
    latch();
    chk("bo_sel", 32'(sel), 32'h01);
    chk("bo_seg", 32'(seg), 32'hA5);
    chk("bo_vpulses", 32'(vpulses), 32'h2);
    chk("bo_cnt", 32'(frame_cnt), 32'h2);

    // oe -> blank with one clock of latency, outputs untouched
    @(negedge clk);
    oe = 1'b0;
    #1;
    chk("oe0_blank_before", 32'(blank), 32'h1);
    @(negedge clk);
    #1;
    chk("oe0_blank_after", 32'(blank), 32'h0);
    chk("oe0_sel", 32'(sel), 32'h01);
    chk("oe0_seg", 32'(seg), 32'hA5);
    @(negedge clk);
    oe = 1'b1;
    #1;
    chk("oe1_blank_before", 32'(blank), 32'h0);
    @(negedge clk);
    #1;
    chk("oe1_blank_after", 32'(blank), 32'h1);
    chk("oe1_sel", 32'(sel), 32'h01);
    chk("oe1_seg", 32'(seg), 32'hA5);

    // Short frame: 10 bits
    send_bits(10, 1);
    latch();
    chk("short_epulses", 32'(epulses), 32'h1);
    chk("short_sel", 32'(sel), 32'h01);
    chk("short_seg", 32'(seg), 32'hA5);
    chk("short_cnt", 32'(frame_cnt), 32'h2);

    // Long frame: 16 bits
    send_bits(16, 1);
    latch();
    chk("long_epulses", 32'(epulses), 32'h2);
    chk("long_cnt", 32'(frame_cnt), 32'h2);
    chk("long_sel", 32'(sel), 32'h01);
    chk("long_seg", 32'(seg), 32'hA5);

    // Latch with nothing shifted
    latch();
    chk("empty_epulses", 32'(epulses), 32'h3);
    chk("empty_vpulses", 32'(vpulses), 32'h2);

    // Stall after 5 bits: no error yet at 10 idle clocks, exactly one by 20
    send_bits(5, 1);
    repeat (9) @(negedge clk);
    #1;
    chk("to_early_epulses", 32'(epulses), 32'h3);
    repeat (10) @(negedge clk);
    #1;
    chk("to_epulses", 32'(epulses), 32'h4);
    send_frame(6'b010101, 8'h3C, 1);
    latch();
    chk("to_next_sel", 32'(sel), 32'h15);
    chk("to_next_seg", 32'(seg), 32'h3C);
    chk("to_next_cnt", 32'(frame_cnt), 32'h3);
    chk("to_next_epulses", 32'(epulses), 32'h4);

    // 14th bit arriving together with stcp still commits
    bits = 14'b01010110100101;
    for (int i = 13; i >= 1; i--) send_bit(bits[i], 1);
    @(negedge clk);
    ds   = bits[0];
    shcp = 1'b1;
    stcp = 1'b1;
    @(negedge clk);
    shcp = 1'b0;
    stcp = 1'b0;
    @(negedge clk);
    #1;
    chk("same_sel", 32'(sel), 32'h2A);
    chk("same_seg", 32'(seg), 32'hA5);
    chk("same_cnt", 32'(frame_cnt), 32'h4);
    chk("same_epulses", 32'(epulses), 32'h4);

    // Reset after 7 bits, then a clean frame
    send_bits(7, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(6'b011011, 8'h5A, 2);
    latch();
    chk("post_rst_sel", 32'(sel), 32'h1B);
    chk("post_rst_seg", 32'(seg), 32'h5A);
    chk("post_rst_cnt", 32'(frame_cnt), 32'h1);
    chk("post_rst_epulses", 32'(epulses), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
